// File: rtl/regfile_fwd_sb_pkg.sv
// Shared constants and forwarding-channel field helpers for regfile_fwd_sb.
// Channel layout: {we, data_ok, waddr[4:0], wdata[31:0]}.
package regfile_fwd_sb_pkg;

  localparam int unsigned FWD_W       = 39;
  localparam int unsigned FWD_WE      = 38;
  localparam int unsigned FWD_OK      = 37;
  localparam int unsigned FWD_ADDR_HI = 36;
  localparam int unsigned FWD_ADDR_LO = 32;
  localparam int unsigned FWD_DATA_HI = 31;
  localparam int unsigned FWD_DATA_LO = 0;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

  function automatic logic fwd_match(input logic [FWD_W-1:0] ch, input logic [4:0] addr);
    return ch[FWD_WE] && (ch[FWD_ADDR_HI:FWD_ADDR_LO] == addr);
  endfunction

  function automatic logic fwd_ok(input logic [FWD_W-1:0] ch);
    return ch[FWD_OK];
  endfunction

  function automatic logic [31:0] fwd_wdata(input logic [FWD_W-1:0] ch);
    return ch[FWD_DATA_HI:FWD_DATA_LO];
  endfunction

endpackage

// File: rtl/regfile_fwd_sb_fwd_sel.sv
// Per-read-port operand select: bypass network, WB write-through, array, stall.
// Bypass channels are used only when REGFILE_FWD_EN is defined.
module regfile_fwd_sb_fwd_sel
  import regfile_fwd_sb_pkg::*;
#(
  parameter int unsigned NFWD = 3
) (
  input  logic [4:0]            addr,
  input  logic                  busy,
  input  logic [NFWD*FWD_W-1:0] fwd_bus,
  input  logic                  wb_we,
  input  logic [4:0]            wb_addr,
  input  logic [31:0]           wb_data,
  input  logic [31:0]           arr_data,
  output logic [31:0]           data,
  output logic                  need_stall
);

`ifndef REGFILE_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^fwd_bus;
`endif

  logic hit;

  always_comb begin
    data       = arr_data;
    need_stall = 1'b0;
    hit        = 1'b0;
    if (addr == REG_ZERO) begin
      data = '0;
    end else begin
      if (wb_we && (wb_addr == addr)) begin
        data = wb_data;
        hit  = 1'b1;
      end
`ifdef REGFILE_FWD_EN
      // Walk oldest to youngest so the youngest match (and its data_ok) wins.
      for (int unsigned k = 0; k < NFWD; k++) begin
        if (fwd_match(fwd_bus[(NFWD-1-k)*FWD_W +: FWD_W], addr)) begin
          data       = fwd_wdata(fwd_bus[(NFWD-1-k)*FWD_W +: FWD_W]);
          hit        = 1'b1;
          need_stall = !fwd_ok(fwd_bus[(NFWD-1-k)*FWD_W +: FWD_W]);
        end
      end
`endif
      if (!hit) begin
        need_stall = busy;
      end
    end
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// ID-stage 32x32 register file with forwarding, WB write-through and in-flight scoreboard.
// Define REGFILE_FWD_EN to enable the fwd_bus bypass network.
module regfile_fwd_sb
  import regfile_fwd_sb_pkg::*;
#(
  parameter int unsigned NREAD = 2,
  parameter int unsigned NFWD  = 3,
  parameter int unsigned CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*5-1:0]    rd_addr,
  output logic [NREAD*32-1:0]   rd_data,
  output logic                  rd_stall,
  input  logic [NFWD*FWD_W-1:0] fwd_bus,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_waddr,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic                  flush,
  output logic                  sb_ovf
);

  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [CNT_W-1:0] cnt_q  [32];
  logic [CNT_W-1:0] cnt_d  [32];
  logic             sb_ovf_q, sb_ovf_d;
  logic [31:0]      inc_v, dec_v;
  logic [NREAD-1:0] stall_vec;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [4:0]  a;
    logic [31:0] d;
    logic        s;
    assign a = rd_addr[5*i +: 5];
    regfile_fwd_sb_fwd_sel #(.NFWD(NFWD)) u_sel (
      .addr       (a),
      .busy       (cnt_q[a] != '0),
      .fwd_bus    (fwd_bus),
      .wb_we      (we),
      .wb_addr    (waddr),
      .wb_data    (wdata),
      .arr_data   (regs_q[a]),
      .data       (d),
      .need_stall (s)
    );
    // Outputs are forced quiet while reset is asserted.
    assign rd_data[32*i +: 32] = resetn ? d : '0;
    assign stall_vec[i]        = rd_en[i] && s;
  end

  assign rd_stall = resetn && (|stall_vec);
  assign sb_ovf   = sb_ovf_q;

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != REG_ZERO)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned r = 0; r < 32; r++) begin
      inc_v[r] = iss_valid && (iss_waddr == 5'(r)) && (iss_waddr != REG_ZERO) && !rd_stall;
      dec_v[r] = we && (waddr == 5'(r)) && (cnt_q[r] != '0);
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sb_ovf_d = sb_ovf_q;
    for (int unsigned r = 0; r < 32; r++) begin
      if (inc_v[r] && !dec_v[r]) begin
        if (cnt_q[r] == '1) begin
          sb_ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end
      end else if (dec_v[r] && !inc_v[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    if (flush) begin
      for (int unsigned r = 0; r < 32; r++) begin
        cnt_d[r] = '0;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned r = 0; r < 32; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_ovf_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_ovf_q <= sb_ovf_d;
    end
  end

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Scoreboard bench for regfile_fwd_sb: stimulus queues expectations, a negedge monitor checks them.
// Expectations adapt to whether REGFILE_FWD_EN is defined.
module tb_regfile_fwd_sb;

  localparam int unsigned NREAD = 2;
  localparam int unsigned NFWD  = 3;
`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NREAD-1:0]     rd_en;
  logic [NREAD*5-1:0]   rd_addr;
  logic [NREAD*32-1:0]  rd_data;
  logic                 rd_stall;
  logic [NFWD*39-1:0]   fwd_bus;
  logic                 iss_valid;
  logic [4:0]           iss_waddr;
  logic                 we;
  logic [4:0]           waddr;
  logic [31:0]          wdata;
  logic                 flush;
  logic                 sb_ovf;

  regfile_fwd_sb #(.NREAD(NREAD), .NFWD(NFWD), .CNT_W(2)) dut (
    .clk(clk), .resetn(resetn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_stall(rd_stall), .fwd_bus(fwd_bus), .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .we(we), .waddr(waddr), .wdata(wdata), .flush(flush), .sb_ovf(sb_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned kind;   // 0 = rd_data[port], 1 = rd_stall, 2 = sb_ovf
    int unsigned port;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string name, input int unsigned kind, input int unsigned port,
                      input logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.port = port; e.val = val;
    q.push_back(e);
  endtask

  task automatic exp_data(input string n, input int unsigned p, input logic [31:0] v);
    push(n, 0, p, v);
  endtask
  task automatic exp_stall(input string n, input logic v);
    push(n, 1, 0, {31'd0, v});
  endtask
  task automatic exp_ovf(input string n, input logic v);
    push(n, 2, 0, {31'd0, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    rd_en = '0; rd_addr = '0; fwd_bus = '0; iss_valid = 1'b0; iss_waddr = '0;
    we = 1'b0; waddr = '0; wdata = '0; flush = 1'b0;
  endtask

  task automatic rd(input int unsigned p, input logic [4:0] a);
    rd_en[p] = 1'b1;
    rd_addr[5*p +: 5] = a;
  endtask

  task automatic set_fwd(input int unsigned j, input logic w, input logic ok,
                         input logic [4:0] a, input logic [31:0] d);
    fwd_bus[j*39 +: 39] = {w, ok, a, d};
  endtask

  task automatic iss(input logic [4:0] a);
    iss_valid = 1'b1; iss_waddr = a;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due at the next negedge.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          0:       act = rd_data[32*e.port +: 32];
          1:       act = {31'd0, rd_stall};
          default: act = {31'd0, sb_ovf};
        endcase
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    clear();
    resetn = 1'b0;
    step();
    clear(); rd(0, 5'd5); set_fwd(0, 1'b1, 1'b0, 5'd5, 32'hAAAA);
    exp_data("reset_rd_data", 0, 32'h0);
    exp_stall("reset_rd_stall", 1'b0);
    exp_ovf("reset_sb_ovf", 1'b0);
    step();
    clear(); resetn = 1'b1;

    // Test 1: array cleared, r0 hardwired
    for (int unsigned a = 1; a < 32; a++) begin
      step(); clear();
      rd(0, 5'(a)); rd(1, 5'(32 - a));
      exp_data("init_zero_p0", 0, 32'h0);
      exp_data("init_zero_p1", 1, 32'h0);
    end
    step(); clear(); wb(5'd0, 32'hFFFF_FFFF); rd(0, 5'd0);
    exp_data("r0_write_through", 0, 32'h0);
    step(); clear(); rd(0, 5'd0);
    exp_data("r0_read", 0, 32'h0);
    step(); clear(); wb(5'd6, 32'hDEAD_BEEF); rd(1, 5'd6);
    exp_data("wb_write_through", 1, 32'hDEAD_BEEF);
    step(); clear(); rd(0, 5'd6);
    exp_data("array_read", 0, 32'hDEAD_BEEF);

    // Test 2: youngest channel wins
    step(); clear(); rd(0, 5'd5);
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'hAAAA); set_fwd(1, 1'b1, 1'b1, 5'd5, 32'hBBBB);
    exp_data("fwd_youngest", 0, FWD ? 32'hAAAA : 32'h0);
    exp_stall("fwd_ready_nostall", 1'b0);
    step(); clear(); rd(0, 5'd5);
    set_fwd(0, 1'b1, 1'b1, 5'd8, 32'hAAAA); set_fwd(1, 1'b1, 1'b1, 5'd5, 32'hBBBB);
    exp_data("fwd_ch1_only", 0, FWD ? 32'hBBBB : 32'h0);

    // Test 3: load-use
    step(); clear(); rd(1, 5'd7); set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0);
    exp_stall("load_use_stall", FWD);
    step(); clear(); rd(1, 5'd7); set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h1234);
    exp_data("load_use_mem_data", 1, FWD ? 32'h1234 : 32'h0);
    exp_stall("load_use_mem_nostall", 1'b0);
    step(); clear(); rd(1, 5'd7);
    set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0); set_fwd(2, 1'b1, 1'b1, 5'd7, 32'h5555);
    exp_stall("older_ready_no_override", FWD);
    step(); clear(); rd_addr[9:5] = 5'd7; set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0);
    exp_stall("rd_en_masks_stall", 1'b0);

    // Test 4: scoreboard counting
    step(); clear(); iss(5'd9);
    step(); clear(); iss(5'd9);
    step(); clear(); wb(5'd9, 32'h99);
    step(); clear(); rd(0, 5'd9);
    exp_stall("cnt1_stall", 1'b1);
    exp_data("cnt1_data", 0, 32'h99);
    step(); clear(); iss(5'd9); wb(5'd9, 32'h98);
    step(); clear(); rd(0, 5'd9); iss(5'd10);
    exp_stall("inc_dec_same_cycle", 1'b1);
    step(); clear(); wb(5'd9, 32'h77);
    step(); clear(); rd(0, 5'd9); rd(1, 5'd10);
    exp_stall("cnt0_and_blocked_issue", 1'b0);
    exp_data("cnt0_data", 0, 32'h77);
    step(); clear(); wb(5'd9, 32'h76);
    step(); clear(); iss(5'd9);
    step(); clear(); wb(5'd9, 32'h75);
    step(); clear(); rd(0, 5'd9);
    exp_stall("dec_at_zero_ignored", 1'b0);
    exp_ovf("no_ovf_yet", 1'b0);
    step(); clear(); iss(5'd12);
    step(); clear(); rd(0, 5'd12);
    exp_stall("pre_flush_stall", 1'b1);
    step(); clear(); flush = 1'b1;
    step(); clear(); rd(0, 5'd12);
    exp_stall("post_flush_nostall", 1'b0);

    // Test 5: saturation and sticky overflow
    step(); clear(); iss(5'd3);
    step(); clear(); iss(5'd3);
    step(); clear(); iss(5'd3);
    step(); clear(); iss(5'd3);
    exp_ovf("ovf_after_3", 1'b0);
    step(); clear(); rd(0, 5'd3);
    exp_ovf("ovf_after_4", 1'b1);
    exp_stall("saturated_stall", 1'b1);
    step(); clear(); flush = 1'b1; iss(5'd13);
    step(); clear(); rd(0, 5'd3); rd(1, 5'd13);
    exp_stall("flush_overrides_inc", 1'b0);
    exp_ovf("ovf_sticky", 1'b1);

    // Test 6: interlock vs bypass
    step(); clear(); iss(5'd4);
    step(); clear(); rd(0, 5'd4); set_fwd(0, 1'b1, 1'b1, 5'd4, 32'd5);
    exp_stall("interlock_stall", !FWD);
    exp_data("interlock_data", 0, FWD ? 32'd5 : 32'd0);
    step(); clear(); rd(0, 5'd4); set_fwd(0, 1'b1, 1'b1, 5'd4, 32'd5); wb(5'd4, 32'd5);
    exp_stall("interlock_wb_release", 1'b0);
    exp_data("interlock_wb_data", 0, 32'd5);

    // Reset mid-operation
    step(); clear(); iss(5'd14);
    step(); clear(); resetn = 1'b0; rd(0, 5'd6); set_fwd(0, 1'b1, 1'b0, 5'd6, 32'h0);
    exp_data("midreset_data", 0, 32'h0);
    exp_stall("midreset_stall", 1'b0);
    step(); clear(); resetn = 1'b1;
    step(); clear(); rd(0, 5'd6); rd(1, 5'd14);
    exp_data("post_reset_array", 0, 32'h0);
    exp_stall("post_reset_cnt", 1'b0);
    exp_ovf("post_reset_ovf", 1'b0);

    step(); clear();
    step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
